// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-atomic round-robin arbiter that merges N_CH byte streams into one uart_tx stream.
module uart_tx_arbiter #(
  parameter int N_CH = 4,
  parameter bit HEADER_EN = 1'b1,
  parameter int TIMEOUT = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*N_CH-1:0]       s_axis_tdata,
  input  logic [N_CH-1:0]         s_axis_tvalid,
  input  logic [N_CH-1:0]         s_axis_tlast,
  output logic [N_CH-1:0]         s_axis_tready,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [$clog2(N_CH)-1:0] grant,
  output logic                    busy,
  output logic                    timeout_err
);
  localparam int GW = $clog2(N_CH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, HEADER = 2'd1, FORWARD = 2'd2;

  logic [1:0] state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, cand;
  logic [CW-1:0] stall_q, stall_d;
  logic [7:0] data_q, data_d;
  logic valid_q, valid_d;
  logic load_ok, fwd, beat, stall, found;
  int idx;

  always_comb begin
    load_ok = !valid_q || m_axis_tready;
    fwd = state_q == FORWARD;
    beat = fwd && s_axis_tvalid[grant_q] && load_ok;
    stall = fwd && !s_axis_tvalid[grant_q];
    timeout_err = stall && (stall_q == CW'(TIMEOUT - 1));
    s_axis_tready = '0;
    if (fwd) s_axis_tready[grant_q] = load_ok;
    state_d = state_q;
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    stall_d = (beat || timeout_err) ? '0 : stall ? stall_q + CW'(1) : stall_q;
    valid_d = valid_q && !m_axis_tready;
    data_d = data_q;
    found = 1'b0;
    idx = 0;
    cand = '0;
    if (state_q == IDLE) begin
      // first requester at or after rr_ptr, wrapping modulo N_CH
      for (int i = 0; i < N_CH; i++) begin
        idx = int'(rr_ptr_q) + i;
        cand = GW'(idx >= N_CH ? idx - N_CH : idx);
        if (!found && s_axis_tvalid[cand]) begin
          found = 1'b1;
          grant_d = cand;
          rr_ptr_d = (cand == GW'(N_CH - 1)) ? '0 : cand + GW'(1);
          state_d = HEADER_EN ? HEADER : FORWARD;
        end
      end
    end else if (state_q == HEADER) begin
      if (load_ok) begin
        data_d = {4'hA, 1'b0, 3'(grant_q)};
        valid_d = 1'b1;
        state_d = FORWARD;
      end
    end else if (beat) begin
      data_d = s_axis_tdata[8*grant_q +: 8];
      valid_d = 1'b1;
      state_d = s_axis_tlast[grant_q] ? IDLE : FORWARD;
    end else if (timeout_err) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_ptr_q <= '0;
      stall_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      stall_q <= stall_d;
      data_q <= data_d;
      valid_q <= valid_d;
    end
  end

  assign m_axis_tdata = data_q;
  assign m_axis_tvalid = valid_q;
  assign grant = grant_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench; expected streams come from a packet-level round-robin model.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] s_data;
  logic [3:0] s_valid, s_last, s_ready;
  logic [7:0] m_data;
  logic m_valid, m_ready;
  logic [1:0] grant;
  logic busy, terr;
  logic [31:0] s1_data;
  logic [3:0] s1_valid, s1_last, s1_ready;
  logic [7:0] m1_data;
  logic m1_valid, m1_ready;
  logic [1:0] grant1;
  logic busy1, terr1;

  uart_tx_arbiter #(.N_CH(4), .HEADER_EN(1'b1), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last),
    .s_axis_tready(s_ready), .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .grant(grant), .busy(busy), .timeout_err(terr));

  uart_tx_arbiter #(.N_CH(4), .HEADER_EN(1'b0), .TIMEOUT(8)) dut_nohdr (
    .clk(clk), .rst(rst), .s_axis_tdata(s1_data), .s_axis_tvalid(s1_valid), .s_axis_tlast(s1_last),
    .s_axis_tready(s1_ready), .m_axis_tdata(m1_data), .m_axis_tvalid(m1_valid), .m_axis_tready(m1_ready),
    .grant(grant1), .busy(busy1), .timeout_err(terr1));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, hs1_cyc = -1000, to_cyc = 0, to_cnt = 0, mptr = 0;
  int rdy_mode = 0;
  bit gap_en = 1'b0;
  logic [7:0] chq[4][$];
  bit chl[4][$];
  logic [7:0] mq[4][$];
  int ml[4][$];
  logic [7:0] exp_q[$];
  logic [7:0] pb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // queue one packet (bytes in pb) for channel c; term=0 leaves it without tlast
  task automatic send(input int c, input bit term);
    ml[c].push_back(pb.size());
    for (int i = 0; i < pb.size(); i++) begin
      chq[c].push_back(pb[i]);
      chl[c].push_back(term && i == pb.size() - 1);
      mq[c].push_back(pb[i]);
    end
    pb.delete();
  endtask

  // all queued packets are pending at once, so service order is plain round robin over non-empty channels
  task automatic run_model();
    int c, n;
    while (1) begin
      c = -1;
      for (int i = 0; i < 4; i++)
        if (c < 0 && ml[(mptr + i) % 4].size() > 0) c = (mptr + i) % 4;
      if (c < 0) break;
      exp_q.push_back(8'hA0 | 8'(c));
      n = ml[c].pop_front();
      repeat (n) exp_q.push_back(mq[c].pop_front());
      mptr = (c + 1) % 4;
    end
  endtask

  function automatic bit pending();
    bit p = exp_q.size() > 0;
    for (int c = 0; c < 4; c++) if (chq[c].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string name);
    int t = 0;
    while (pending() && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  // source drivers: first byte of every packet presented immediately, optional gaps only mid-packet
  initial begin
    bit [3:0] hsv;
    int gap[4];
    bit lst;
    s_valid = '0;
    s_last = '0;
    s_data = '0;
    for (int c = 0; c < 4; c++) gap[c] = 0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) hsv[c] = s_valid[c] && s_ready[c];
      if (hsv[1]) hs1_cyc = cyc;
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
        if (hsv[c] && chq[c].size() > 0) begin
          void'(chq[c].pop_front());
          lst = chl[c].pop_front();
          gap[c] = (gap_en && !lst) ? $urandom_range(0, 3) : 0;
        end else if (gap[c] > 0) gap[c]--;
        s_valid[c] = chq[c].size() > 0 && gap[c] == 0;
        s_data[8*c +: 8] = chq[c].size() > 0 ? chq[c][0] : 8'h00;
        s_last[c] = chl[c].size() > 0 ? chl[c][0] : 1'b0;
      end
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 2 ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // monitor: scoreboard pops on every accepted output byte, plus hold/backpressure/grant invariants
  initial begin
    bit hold, pbusy;
    logic [7:0] hold_data;
    logic [1:0] pgrant;
    hold = 0;
    pbusy = 0;
    hold_data = 0;
    pgrant = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0;
        pbusy = 0;
      end else begin
        if (hold) begin
          check("hold_valid", m_valid, 1);
          check("hold_data", m_data, hold_data);
        end
        hold = m_valid && !m_ready;
        hold_data = m_data;
        if (hold) check("bp_sready", s_ready, 0);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_byte actual=%0h expected=none", m_data);
          end else check("out_byte", m_data, exp_q.pop_front());
        end
        if (busy && pbusy) check("grant_stable", grant, pgrant);
        pbusy = busy;
        pgrant = grant;
        if (terr) begin
          to_cnt++;
          to_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    bit seen;
    int fb, fv, n;
    bit hs;
    logic [7:0] b[3];
    logic [7:0] exp1[$];
    rst = 1'b1;
    s1_valid = '0;
    s1_last = '0;
    s1_data = '0;
    m1_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mvalid", m_valid, 0);
    check("rst_mdata", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_sready", s_ready, 0);
    check("rst_terr", terr, 0);
    rst = 1'b0;

    @(negedge clk);
    pb = '{8'h5a};
    send(1, 0);
    pb = '{8'h31, 8'h32};
    send(3, 1);
    run_model();
    drain("timeout_drain");
    check("timeout_cycle", to_cyc - hs1_cyc, 8);
    check("timeout_count", to_cnt, 1);

    @(negedge clk);
    pb = '{8'h11, 8'h22};
    send(2, 1);
    run_model();
    seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (m_valid && m_data == 8'h22) begin
        seen = 1;
        check("single_busy_drop", busy, 0);
      end
    end
    check("single_seen", seen, 1);
    drain("single_drain");

    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      pb = '{8'(16 * k), 8'(16 * k + 1)};
      send(0, 1);
      pb = '{8'(16 * k + 8), 8'(16 * k + 9)};
      send(1, 1);
    end
    run_model();
    drain("fair_drain");

    @(negedge clk);
    pb = '{8'hc1, 8'hc2, 8'hc3, 8'hc4, 8'hc5, 8'hc6};
    send(0, 1);
    run_model();
    repeat (3) @(negedge clk);
    rdy_mode = 2;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp_held_valid", m_valid, 1);
    check("bp_no_sready", s_ready, 0);
    rdy_mode = 0;
    drain("bp_drain");
    check("bp_no_timeout", to_cnt, 1);

    rdy_mode = 1;
    gap_en = 1;
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        repeat ($urandom_range(0, 3)) begin
          repeat ($urandom_range(1, 4)) pb.push_back(8'($urandom));
          send(c, 1);
        end
      end
      run_model();
      drain("rand_drain");
    end
    gap_en = 0;
    check("rand_no_timeout", to_cnt, 1);

    rdy_mode = 2;
    @(negedge clk);
    pb = '{8'h71, 8'h72, 8'h73, 8'h74};
    send(1, 1);
    repeat (4) @(negedge clk);
    check("pre_rst_valid", m_valid, 1);
    check("pre_rst_grant", grant, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_mvalid", m_valid, 0);
    check("arst_mdata", m_data, 0);
    check("arst_busy", busy, 0);
    check("arst_grant", grant, 0);
    check("arst_sready", s_ready, 0);
    for (int c = 0; c < 4; c++) begin
      chq[c].delete();
      chl[c].delete();
      mq[c].delete();
      ml[c].delete();
    end
    exp_q.delete();
    mptr = 0;
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pb = '{8'h81, 8'h82};
    send(2, 1);
    pb = '{8'h91, 8'h92};
    send(0, 1);
    run_model();
    drain("arst_drain");

    b = '{8'h3c, 8'hc3, 8'h7e};
    for (int i = 0; i < 3; i++) exp1.push_back(b[i]);
    @(negedge clk);
    s1_data[7:0] = b[0];
    s1_last[0] = 1'b0;
    s1_valid[0] = 1'b1;
    n = 0;
    fb = -1;
    fv = -1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      hs = s1_valid[0] && s1_ready[0];
      if (busy1 && fb < 0) fb = t;
      if (m1_valid && fv < 0) fv = t;
      if (m1_valid) begin
        if (exp1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL nohdr_extra actual=%0h expected=none", m1_data);
        end else check("nohdr_byte", m1_data, exp1.pop_front());
      end
      @(posedge clk);
      #1;
      if (hs) begin
        n++;
        if (n == 3) s1_valid[0] = 1'b0;
        else begin
          s1_data[7:0] = b[n];
          s1_last[0] = n == 2;
        end
      end
    end
    check("nohdr_latency", fv, fb + 1);
    check("nohdr_left", exp1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
